pair_exit_fifo_param: RTL

- Parametrised, frame-scheduled exit FIFO for pair records leaving the pair pipeline.
- A free-running slot counter divides time into frames of FRAME_LEN cycles. Inputs are captured during the first WR_SLOTS slots of each frame. At most one record is popped per frame, in the last slot.
- The output is registered and held for a full frame. A null word (MSB=1, rest 0) is presented when nothing is available.
- Owns its storage (circular buffer) and adds occupancy, sticky overflow and frame-slot visibility.

---
 rtl/pair_exit_fifo_param.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pair_exit_fifo_param.sv
// Frame-scheduled exit FIFO for pair records leaving the pair pipeline.
// Optional null-word filter on writes: define PAIR_EXIT_NULL_FILTER_EN.
module pair_exit_fifo_param #(
    parameter int DATA_W    = 227,
    parameter int DEPTH     = 64,
    parameter int FRAME_LEN = 16,
    parameter int WR_SLOTS  = 14
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            in,
    output logic [DATA_W-1:0]            out,
    output logic                         qempty,
    output logic [$clog2(FRAME_LEN)-1:0] slot,
    output logic                         frame_start,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int SLOT_W = $clog2(FRAME_LEN);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);
    localparam logic [SLOT_W-1:0] WR_END    = SLOT_W'(WR_SLOTS);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [DATA_W-1:0] NULL_WORD = {1'b1, {(DATA_W-1){1'b0}}};

    // Reject illegal configurations at elaboration time.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pair_exit_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (FRAME_LEN < 2) begin : g_bad_frame
        $error("pair_exit_fifo_param: FRAME_LEN must be >= 2");
    end
    if (WR_SLOTS < 1 || WR_SLOTS > FRAME_LEN - 1) begin : g_bad_wr
        $error("pair_exit_fifo_param: WR_SLOTS must be 1..FRAME_LEN-1");
    end

    logic [SLOT_W-1:0] slot_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] out_q;
    logic              qempty_q;
    logic              overflow_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic in_window;
    logic read_slot;
    logic word_ok;
    logic wr_req;
    logic full;
    logic wr_fire;
    logic rd_fire;

    assign in_window = slot_q < WR_END;
    assign read_slot = slot_q == LAST_SLOT;

`ifdef PAIR_EXIT_NULL_FILTER_EN
    // Null words are padding; they never occupy a buffer entry.
    assign word_ok = ~in[DATA_W-1];
`else
    assign word_ok = 1'b1;
`endif

    // Full/empty is decided from count alone, so pointers may wrap freely.
    assign wr_req  = in_window & word_ok;
    assign full    = count_q == FULL_CNT;
    assign wr_fire = wr_req & ~full;
    assign rd_fire = read_slot & (count_q != '0);

    // Free-running slot counter; reset parks it on the read slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= LAST_SLOT;
        end else if (read_slot) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_q + 1'b1;
        end
    end

    // Buffer storage; contents are not reset, a reset edge blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && wr_fire) begin
            mem[wr_ptr] <= in;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop never share a slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (wr_fire) begin
            wr_ptr  <= wr_ptr + 1'b1;
            count_q <= count_q + 1'b1;
        end else if (rd_fire) begin
            rd_ptr  <= rd_ptr + 1'b1;
            count_q <= count_q - 1'b1;
        end
    end

    // Sticky flag for a write lost to a full buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (wr_req && full) begin
            overflow_q <= 1'b1;
        end
    end

    // Output register, reloaded once per frame in the read slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= NULL_WORD;
            qempty_q <= 1'b1;
        end else if (read_slot) begin
            if (rd_fire) begin
                out_q    <= mem[rd_ptr];
                qempty_q <= 1'b0;
            end else begin
                out_q    <= NULL_WORD;
                qempty_q <= 1'b1;
            end
        end
    end

    assign out         = out_q;
    assign qempty      = qempty_q;
    assign slot        = slot_q;
    assign frame_start = slot_q == '0;
    assign count       = count_q;
    assign overflow    = overflow_q;

endmodule
